// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two registered read ports. Register 0 always reads as zero.
// Define REGFILE_BYPASS_EN for write-first same-edge reads. Without it, a same-edge read returns the old value.
module reg_file_2r1w #(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 8,
  parameter int               AW    = 3,
  parameter logic [WIDTH-1:0] RVAL  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b
);

  // All registers, flattened; slice 0 is the hardwired zero register.
  logic [DEPTH*WIDTH-1:0]  store;
  logic [1:0]              re;
  logic [1:0][AW-1:0]      raddr;
  logic [1:0][WIDTH-1:0]   rdata_all;
  logic [1:0]              rvalid_all;

  assign store[WIDTH-1:0] = '0;

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q_reg <= RVAL;
      end else if (we && waddr == AW'(gi)) begin
        q_reg <= wdata;
      end
    end

    assign store[gi*WIDTH +: WIDTH] = q_reg;
  end

  assign re    = {re_b, re_a};
  assign raddr = {raddr_b, raddr_a};

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [WIDTH-1:0] rdata_next;
    logic [WIDTH-1:0] rdata_reg;
    logic             rvalid_reg;

    // Addresses 0 and >= DEPTH never match, so they fall through to zero.
    always_comb begin
      rdata_next = '0;
      for (int i = 1; i < DEPTH; i++) begin
        if (raddr[gi] == AW'(i)) begin
          rdata_next = store[i*WIDTH +: WIDTH];
`ifdef REGFILE_BYPASS_EN
          if (we && waddr == AW'(i)) begin
            rdata_next = wdata;
          end
`endif
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata_reg  <= '0;
        rvalid_reg <= 1'b0;
      end else begin
        rvalid_reg <= re[gi];
        if (re[gi]) begin
          rdata_reg <= rdata_next;
        end
      end
    end

    assign rdata_all[gi]  = rdata_reg;
    assign rvalid_all[gi] = rvalid_reg;
  end

  assign rdata_a  = rdata_all[0];
  assign rvalid_a = rvalid_all[0];
  assign rdata_b  = rdata_all[1];
  assign rvalid_b = rvalid_all[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: directed vector table, reset/out-of-range sequences and randomized
// traffic against an array model, on a DEPTH=8 (RVAL=A5A5) and a DEPTH=6 instance.
module tb_reg_file_2r1w;

`ifdef REGFILE_BYPASS_EN
  localparam bit          BYP     = 1'b1;
  localparam logic [15:0] HIT_VAL = 16'h0055;
`else
  localparam bit          BYP     = 1'b0;
  localparam logic [15:0] HIT_VAL = 16'h00AA;
`endif

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        re_a;
  logic [2:0]  raddr_a;
  logic        re_b;
  logic [2:0]  raddr_b;
  logic [15:0] rda [2];
  logic [15:0] rdb [2];
  logic        rva [2];
  logic        rvb [2];

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference model: index 0 -> DEPTH=8 instance, index 1 -> DEPTH=6 instance
  logic [15:0] mem [2][8];
  int          dep [2] = '{8, 6};
  logic [15:0] rv  [2] = '{16'hA5A5, 16'h0000};
  logic [15:0] exp_a [2];
  logic [15:0] exp_b [2];
  logic        exp_va [2];
  logic        exp_vb [2];

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .AW(3), .RVAL(16'hA5A5)) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[0]), .rvalid_a(rva[0]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[0]), .rvalid_b(rvb[0])
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .AW(3), .RVAL(16'h0000)) dut6 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[1]), .rvalid_a(rva[1]),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[1]), .rvalid_b(rvb[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mread(input int k, input logic [2:0] addr);
    if (addr == 3'd0 || int'(addr) >= dep[k]) return 16'h0000;
    if (BYP && we && waddr == addr) return wdata;
    return mem[k][addr];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = (i == 0) ? 16'h0000 : rv[k];
      exp_a[k] = 16'h0000; exp_b[k] = 16'h0000;
      exp_va[k] = 1'b0;    exp_vb[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s d%0d rdata_a", tag, dep[k]), rda[k], exp_a[k]);
      check($sformatf("%s d%0d rvalid_a", tag, dep[k]), {15'd0, rva[k]}, {15'd0, exp_va[k]});
      check($sformatf("%s d%0d rdata_b", tag, dep[k]), rdb[k], exp_b[k]);
      check($sformatf("%s d%0d rvalid_b", tag, dep[k]), {15'd0, rvb[k]}, {15'd0, exp_vb[k]});
    end
  endtask

  // One clock edge with the current inputs; model reads use pre-edge state.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      exp_va[k] = re_a;
      exp_vb[k] = re_b;
      if (re_a) exp_a[k] = mread(k, raddr_a);
      if (re_b) exp_b[k] = mread(k, raddr_b);
    end
    for (int k = 0; k < 2; k++)
      if (we && waddr != 3'd0 && int'(waddr) < dep[k]) mem[k][waddr] = wdata;
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d we=%b wa=%0d wd=%h ra=%b:%0d rb=%b:%0d -> a=%h/%b b=%h/%b a6=%h/%b b6=%h/%b",
             txn, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
             rda[0], rva[0], rdb[0], rvb[0], rda[1], rva[1], rdb[1], rvb[1]);
    check_all($sformatf("txn%0d", txn));
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        re_a;
    logic [2:0]  raddr_a;
    logic        re_b;
    logic [2:0]  raddr_b;
    logic [15:0] ea;
    logic        eva;
    logic [15:0] eb;
    logic        evb;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 3'd5, 16'h1234, 1'b1, 16'h1234, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd5, 1'b0, 3'd0, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[3]  = '{1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[5]  = '{1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[6]  = '{1'b1, 3'd2, 16'h0055, 1'b1, 3'd2, 1'b0, 3'd0, HIT_VAL,  1'b1, 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0, 16'h0055, 1'b1, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 3'd1, 16'h0011, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0055, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 3'd7, 16'h0077, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0055, 1'b0, 16'h0000, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 3'd7, 16'h0011, 1'b1, 16'h0077, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 1'b1, 3'd7, 16'h0077, 1'b1, 16'h0077, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd3, 16'h0077, 1'b0, 16'hA5A5, 1'b1};

    reset = 1'b1;
    we = 1'b0; waddr = 3'd0; wdata = 16'h0000;
    re_a = 1'b0; raddr_a = 3'd0; re_b = 1'b0; raddr_b = 3'd0;
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("por");
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // Directed vector table (expected columns are for the DEPTH=8 instance)
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      re_a = tbl[i].re_a; raddr_a = tbl[i].raddr_a;
      re_b = tbl[i].re_b; raddr_b = tbl[i].raddr_b;
      cycle();
      check($sformatf("vec%0d rdata_a", i), rda[0], tbl[i].ea);
      check($sformatf("vec%0d rvalid_a", i), {15'd0, rva[0]}, {15'd0, tbl[i].eva});
      check($sformatf("vec%0d rdata_b", i), rdb[0], tbl[i].eb);
      check($sformatf("vec%0d rvalid_b", i), {15'd0, rvb[0]}, {15'd0, tbl[i].evb});
    end

    // Reset asserted between edges while a write to reg3 is pending
    we = 1'b1; waddr = 3'd3; wdata = 16'hBEEF;
    re_a = 1'b0; re_b = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #3 reset = 1'b1;
    we = 1'b0;
    re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd5;
    cycle();
    check("rst reg3", rda[0], 16'hA5A5);
    check("rst reg5", rdb[0], 16'hA5A5);

    // Out-of-range write/read on the DEPTH=6 instance
    we = 1'b1; waddr = 3'd6; wdata = 16'h0F0F; re_a = 1'b0; re_b = 1'b0;
    cycle();
    we = 1'b0; re_a = 1'b1; raddr_a = 3'd6; re_b = 1'b1; raddr_b = 3'd7;
    cycle();
    check("d6 oob rdata_a", rda[1], 16'h0000);
    check("d6 oob rvalid_a", {15'd0, rva[1]}, 16'h0001);
    check("d6 oob rdata_b", rdb[1], 16'h0000);
    check("d8 reg6 rdata_a", rda[0], 16'h0F0F);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 3'($urandom_range(0, 7));
      wdata   = 16'($urandom);
      re_a    = 1'($urandom_range(0, 3) != 0);
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      re_b    = 1'($urandom_range(0, 3) != 0);
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
